// File: rtl/ram_pkg.sv
// Shared constants and types for the CBUS-to-RAM controller.
//   DEF_ADDR_WIDTH   : default RAM word-address width
//   DEF_DATA_WIDTH   : default RAM word width
//   DEF_READ_LATENCY : default RAM read latency (cycles)
//   state_e          : controller FSM states
package ram_pkg;
  localparam int DEF_ADDR_WIDTH   = 17;
  localparam int DEF_DATA_WIDTH   = 64;
  localparam int DEF_READ_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;
endpackage

// File: rtl/cbus_ram_ctrl_if.sv
// Bus bundle between a CBUS master, the controller and a single-port RAM.
//   req_*    : master request (held until the last beat handshake)
//   resp_*   : per-beat completion back to the master
//   ram_*    : RAM port
// Modports: master (bus master), slave (controller), ram (memory).
interface cbus_ram_ctrl_if
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_is_write;
  logic [63:0]           req_addr;
  logic [3:0]            req_len;
  logic [BYTES-1:0]      req_strobe;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  resp_ready;
  logic                  resp_last;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  ram_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [BYTES-1:0]      ram_strobe;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport master (
    output req_valid, req_is_write, req_addr, req_len, req_strobe, req_data,
    input  resp_ready, resp_last, resp_data
  );

  modport slave (
    input  req_valid, req_is_write, req_addr, req_len, req_strobe, req_data,
    output resp_ready, resp_last, resp_data,
    output ram_en, ram_addr, ram_strobe, ram_wdata,
    input  ram_rdata
  );

  modport ram (
    input  ram_en, ram_addr, ram_strobe, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/ram_read_pipe.sv
// Read-tag delay line: a {valid, last} tag pushed with each issued RAM read
// emerges READ_LATENCY cycles later, aligned with the RAM read data.
//   clk, resetn     : clock, async active-low reset (clears all tags)
//   push, push_last : tag in (read issued this cycle / it is the final beat)
//   valid, last     : tag out
module ram_read_pipe
  import ram_pkg::*;
#(
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_last,
  output logic valid,
  output logic last
);
  logic [READ_LATENCY-1:0] vld_pipe_q;
  logic [READ_LATENCY-1:0] last_pipe_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      vld_pipe_q[0]  <= push;
      last_pipe_q[0] <= push & push_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
    end
  end

  assign valid = vld_pipe_q[READ_LATENCY-1];
  assign last  = last_pipe_q[READ_LATENCY-1];
endmodule

// File: rtl/cbus_ram_ctrl.sv
// CBUS burst slave driving a single-port RAM. INCR bursts of 1..16 beats,
// word address wraps modulo 2^ADDR_WIDTH. Writes complete combinationally one
// beat per cycle; reads are issued back-to-back and answered READ_LATENCY
// cycles later through a tag delay line. No response backpressure.
//   clk, resetn : clock, async active-low reset
//   bus         : slave view of the request/response and RAM signals
module cbus_ram_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic            clk,
  input  logic            resetn,
  cbus_ram_ctrl_if.slave  bus
);
  localparam int BYTES = DATA_WIDTH / 8;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [3:0]            len_q, len_d;
  // 5 bits so a 16-beat read can count past the last beat and stop issuing.
  logic [4:0]            cnt_q, cnt_d;

  logic                  push, push_last, tag_vld, tag_last;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic                  beat_is_last;

  // Byte offset and address bits above the RAM range are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[63:ADDR_WIDTH+3], bus.req_addr[2:0]};

  assign beat_addr    = base_q + ADDR_WIDTH'(cnt_q);
  assign beat_is_last = (cnt_q[3:0] == len_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    push           = 1'b0;
    push_last      = 1'b0;
    bus.ram_en     = 1'b0;
    bus.ram_addr   = '0;
    bus.ram_strobe = '0;
    bus.ram_wdata  = '0;
    bus.resp_ready = 1'b0;
    bus.resp_last  = 1'b0;
    bus.resp_data  = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          base_d  = bus.req_addr[ADDR_WIDTH+2:3];
          len_d   = bus.req_len;
          cnt_d   = '0;
          state_d = bus.req_is_write ? WRITE : READ;
        end
      end
      WRITE: begin
        bus.ram_en     = 1'b1;
        bus.ram_addr   = beat_addr;
        bus.ram_strobe = bus.req_strobe;
        bus.ram_wdata  = bus.req_data;
        bus.resp_ready = 1'b1;
        bus.resp_last  = beat_is_last;
        cnt_d          = cnt_q + 5'd1;
        if (beat_is_last) state_d = IDLE;
      end
      READ: begin
        // Issue side runs ahead of the response side by READ_LATENCY.
        if (cnt_q <= {1'b0, len_q}) begin
          bus.ram_en   = 1'b1;
          bus.ram_addr = beat_addr;
          push         = 1'b1;
          push_last    = beat_is_last;
          cnt_d        = cnt_q + 5'd1;
        end
        bus.resp_ready = tag_vld;
        bus.resp_last  = tag_vld & tag_last;
        bus.resp_data  = tag_vld ? bus.ram_rdata : '0;
        if (tag_vld && tag_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  ram_read_pipe #(.READ_LATENCY(READ_LATENCY)) u_read_pipe (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_last (push_last),
    .valid     (tag_vld),
    .last      (tag_last)
  );
endmodule

// File: tb/tb_cbus_ram_ctrl.sv
// Directed bench for cbus_ram_ctrl with a behavioural RAM of READ_LATENCY.
module tb_cbus_ram_ctrl;
  localparam int AW = 17;
  localparam int DW = 64;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cbus_ram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cbus_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  // RAM model: byte-masked write, read data valid RL cycles after enable.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [RL];

  always @(posedge clk) begin
    if (bus.ram_en) begin
      for (int b = 0; b < DW/8; b++)
        if (bus.ram_strobe[b]) mem[bus.ram_addr][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
      rd_pipe[0] <= mem[bus.ram_addr];
    end else begin
      rd_pipe[0] <= '0;
    end
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.ram_rdata = rd_pipe[RL-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_req();
    bus.req_valid    = 1'b0;
    bus.req_is_write = 1'b0;
    bus.req_addr     = '0;
    bus.req_len      = '0;
    bus.req_strobe   = '0;
    bus.req_data     = '0;
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
  task automatic wr(input logic [63:0] a, input logic [3:0] len, input logic [7:0] strb,
                    input logic [63:0] d0, input logic [63:0] dstep);
    logic [AW-1:0] ea;
    bus.req_valid    = 1'b1;
    bus.req_is_write = 1'b1;
    bus.req_addr     = a;
    bus.req_len      = len;
    @(posedge clk); #1;
    for (int i = 0; i <= int'(len); i++) begin
      bus.req_data   = d0 + 64'(i) * dstep;
      bus.req_strobe = strb;
      ea = a[AW+2:3] + AW'(i);
      #1;
      chk("wr_ready",  64'(bus.resp_ready), 64'd1);
      chk("wr_last",   64'(bus.resp_last),  64'(i == int'(len)));
      chk("wr_addr",   64'(bus.ram_addr),   64'(ea));
      chk("wr_strobe", 64'(bus.ram_strobe), 64'(strb));
      @(posedge clk); #1;
    end
    idle_req();
  endtask

  task automatic rd(input logic [63:0] a, input logic [3:0] len,
                    input logic [63:0] d0, input logic [63:0] dstep);
    int beat;
    bus.req_valid    = 1'b1;
    bus.req_is_write = 1'b0;
    bus.req_addr     = a;
    bus.req_len      = len;
    @(posedge clk); #1;   // first READ cycle
    for (int c = 0; c <= RL + int'(len); c++) begin
      #1;
      if (c < RL) begin
        chk("rd_early_ready", 64'(bus.resp_ready), 64'd0);
        chk("rd_early_data",  bus.resp_data,       64'd0);
      end else begin
        beat = c - RL;
        chk("rd_ready", 64'(bus.resp_ready), 64'd1);
        chk("rd_last",  64'(bus.resp_last),  64'(beat == int'(len)));
        chk("rd_data",  bus.resp_data,       d0 + 64'(beat) * dstep);
      end
      @(posedge clk); #1;
    end
    idle_req();
    #1;
    chk("rd_after_ready", 64'(bus.resp_ready), 64'd0);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ready"},  64'(bus.resp_ready), 64'd0);
    chk({tag, "_last"},   64'(bus.resp_last),  64'd0);
    chk({tag, "_rdata"},  bus.resp_data,       64'd0);
    chk({tag, "_en"},     64'(bus.ram_en),     64'd0);
    chk({tag, "_addr"},   64'(bus.ram_addr),   64'd0);
    chk({tag, "_strobe"}, 64'(bus.ram_strobe), 64'd0);
    chk({tag, "_wdata"},  bus.ram_wdata,       64'd0);
  endtask

  initial begin
    int hits;
    idle_req();
    for (int k = 0; k < RL; k++) rd_pipe[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outs_zero("rst");
    #3 resetn = 1'b1;
    @(posedge clk); #1;

    // Single write then read
    wr(64'h8, 4'd0, 8'hFF, 64'h1122334455667788, 64'd0);
    rd(64'h8, 4'd0, 64'h1122334455667788, 64'd0);

    // 4-beat burst
    wr(64'h100, 4'd3, 8'hFF, 64'hA0, 64'd1);
    rd(64'h100, 4'd3, 64'hA0, 64'd1);

    // Partial strobe on word 2
    wr(64'h10, 4'd0, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 64'd0);
    wr(64'h10, 4'd0, 8'h0F, 64'h0, 64'd0);
    rd(64'h10, 4'd0, 64'hFFFFFFFF00000000, 64'd0);

    // Wrap at top of RAM
    wr(64'((1 << AW) - 1) * 64'd8, 4'd1, 8'hFF, 64'h11, 64'h11);
    rd(64'((1 << AW) - 1) * 64'd8, 4'd1, 64'h11, 64'h11);
    rd(64'h0, 4'd0, 64'h22, 64'd0);

    // Zero strobe: handshake completes, memory untouched
    wr(64'h8, 4'd0, 8'h00, 64'hDEADBEEFDEADBEEF, 64'd0);
    rd(64'h8, 4'd0, 64'h1122334455667788, 64'd0);

    // Reset one cycle after READ entry of an 8-beat read
    bus.req_valid    = 1'b1;
    bus.req_is_write = 1'b0;
    bus.req_addr     = 64'h100;
    bus.req_len      = 4'd7;
    @(posedge clk); #1;   // READ entry
    @(posedge clk); #1;   // one cycle later
    resetn = 1'b0;
    #1;
    chk_outs_zero("midrst");
    idle_req();
    @(posedge clk); #3;
    resetn = 1'b1;
    hits = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.resp_ready || bus.ram_en) hits++;
    end
    chk("post_rst_quiet", 64'(hits), 64'd0);

    // Controller still works after the abort
    rd(64'h100, 4'd3, 64'hA0, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
